// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Purpose  : Shared definitions for the TDC register sequencer: command-byte
//            field positions, byte-count constants, FSM state encoding and
//            small helpers for building the outgoing SPI bytes.
// Revision : 1.0 - initial release
// ============================================================================
package tdc_pkg;

    // Command byte layout: {AUTO_INC, RW, ADDR[5:0]}
    localparam int CMD_AUTO_INC_BIT = 7;
    localparam int CMD_RW_BIT       = 6;
    localparam int CMD_ADDR_W       = 6;

    // Bytes per burst, command byte included
    localparam logic [2:0] BYTES_NARROW = 3'd2;
    localparam logic [2:0] BYTES_WIDE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_t;

    // Command byte; auto-increment is never used by this sequencer
    function automatic logic [7:0] make_cmd(input logic write, input logic [CMD_ADDR_W-1:0] addr);
        logic [7:0] cmd;
        cmd                    = '0;
        cmd[CMD_AUTO_INC_BIT]  = 1'b0;
        cmd[CMD_RW_BIT]        = write;
        cmd[CMD_ADDR_W-1:0]    = addr;
        return cmd;
    endfunction

    // Write data byte to send when 'remaining' bytes are still outstanding
    // (last byte of the burst is wdata[7:0], so the data goes out MSB first)
    function automatic logic [7:0] data_byte(input logic [23:0] wdata, input logic [2:0] remaining);
        logic [7:0] b;
        case (remaining)
            3'd3:    b = wdata[23:16];
            3'd2:    b = wdata[15:8];
            default: b = wdata[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tdc_reg_sequencer
// Purpose  : Turns a single TDC register read/write request into a CS-framed
//            SPI burst (command byte + 1 or 3 data bytes) on the byte engine,
//            and assembles the received bytes into a response word. A per-byte
//            watchdog aborts the transaction if the engine never completes.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_reg_sequencer
    import tdc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 10
) (
    input  logic        clk,
    input  logic        rst,
    // request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [5:0]  req_addr,
    input  logic        req_wide,
    input  logic [23:0] req_wdata,
    // response side
    output logic        rsp_valid,
    output logic [23:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    // byte engine side
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    output logic        spi_cs_end,
    input  logic [7:0]  spi_rx,
    input  logic        spi_busy,
    input  logic        spi_new_data
);

    localparam logic [TO_W-1:0] c_wd_max = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t        r_state;
    logic [2:0]        r_remaining;
    logic              r_write;
    logic              r_wide;
    logic [23:0]       r_wdata;
    logic [23:0]       r_rdata;
    logic              r_cmd_phase;
    logic [TO_W-1:0]   r_wd;

    logic [2:0]        w_rem_next;
    logic [23:0]       w_rdata_next;

    assign req_ready = (r_state == ST_IDLE) & ~rst;
    assign busy      = (r_state != ST_IDLE);

    // Byte-complete bookkeeping: remaining count and shifted read data
    always_comb begin
        w_rem_next   = r_remaining - 3'd1;
        w_rdata_next = r_rdata;
        if (!r_write && !r_cmd_phase) begin
            w_rdata_next = {r_rdata[15:0], spi_rx};
        end
    end

    // Sequencer FSM with registered engine and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            spi_start   <= 1'b0;
            spi_tx      <= '0;
            spi_cs_end  <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            r_wd        <= '0;
            r_remaining <= '0;
            r_write     <= 1'b0;
            r_wide      <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_cmd_phase <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_wide      <= req_wide;
                        r_wdata     <= req_wdata;
                        r_rdata     <= '0;
                        r_cmd_phase <= 1'b1;
                        r_remaining <= req_wide ? BYTES_WIDE : BYTES_NARROW;
                        spi_tx      <= make_cmd(req_write, req_addr);
                        // command byte is never the last byte of a burst
                        spi_cs_end  <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!spi_busy) begin
                        spi_start <= 1'b1;
                        r_wd      <= '0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // spi_tx / spi_cs_end are held here: the engine samples them late
                    if (spi_new_data) begin
                        r_rdata     <= w_rdata_next;
                        r_cmd_phase <= 1'b0;
                        r_remaining <= w_rem_next;
                        if (w_rem_next == 3'd0) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            if (r_write) begin
                                rsp_rdata <= '0;
                            end else if (r_wide) begin
                                rsp_rdata <= w_rdata_next;
                            end else begin
                                rsp_rdata <= {16'h0000, w_rdata_next[7:0]};
                            end
                            r_state <= ST_DONE;
                        end else begin
                            spi_tx     <= r_write ? data_byte(r_wdata, w_rem_next) : 8'h00;
                            spi_cs_end <= (w_rem_next == 3'd1);
                            r_state    <= ST_ISSUE;
                        end
                    end else if (r_wd == c_wd_max) begin
                        // CS stays asserted; upstream resets to recover
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        r_state   <= ST_ERR;
                    end else begin
                        r_wd <= r_wd + TO_W'(1);
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdc_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_reg_sequencer
// Purpose  : Directed self-checking bench for tdc_reg_sequencer with a
//            behavioural byte-engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_reg_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [5:0]  req_addr;
    logic        req_wide;
    logic [23:0] req_wdata;
    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_cs_end;
    logic [7:0]  spi_rx;
    logic        spi_busy;
    logic        spi_new_data;

    tdc_reg_sequencer #(.TIMEOUT_CYCLES(64), .TO_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wide     (req_wide),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .spi_start    (spi_start),
        .spi_tx       (spi_tx),
        .spi_cs_end   (spi_cs_end),
        .spi_rx       (spi_rx),
        .spi_busy     (spi_busy),
        .spi_new_data (spi_new_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rsp_cnt = 0;

    // byte engine model state
    logic [7:0] rx_mem [0:63];
    int         rx_wr = 0;
    int         rx_rd = 0;
    logic [7:0] tx_log [0:63];
    logic       cs_log [0:63];
    int         log_n = 0;
    int         eng_cnt = 0;
    int         eng_lat = 4;
    logic       eng_mute = 1'b0;
    int         spur_req = 0;
    int         spur_done = 0;
    int         stab_err = 0;
    int         start_cyc = 0;
    logic [7:0] cur_tx;
    logic       cur_cs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

    // Byte engine: latches tx/cs at start, stays busy eng_lat cycles, then pulses new_data
    always @(negedge clk) begin
        spi_new_data = 1'b0;
        if (rst) begin
            spi_busy = 1'b0;
            eng_cnt  = 0;
        end else if (spur_done != spur_req) begin
            spi_new_data = 1'b1;
            spi_rx       = 8'h99;
            spur_done++;
        end else if (eng_cnt > 0) begin
            if (spi_tx !== cur_tx || spi_cs_end !== cur_cs || spi_start !== 1'b0) stab_err++;
            eng_cnt--;
            if (eng_cnt == 0) begin
                spi_busy     = 1'b0;
                spi_new_data = 1'b1;
                spi_rx       = rx_mem[rx_rd];
                rx_rd++;
            end
        end else if (spi_start === 1'b1) begin
            cur_tx         = spi_tx;
            cur_cs         = spi_cs_end;
            tx_log[log_n]  = spi_tx;
            cs_log[log_n]  = spi_cs_end;
            log_n++;
            start_cyc      = cyc;
            spi_busy       = 1'b1;
            eng_cnt        = eng_mute ? 0 : eng_lat;
        end
    end

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr++;
    endtask

    task automatic send_req(input logic w, input logic [5:0] a, input logic wd, input logic [23:0] d);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                req_valid = 1'b1;
                req_write = w;
                req_addr  = a;
                req_wide  = wd;
                req_wdata = d;
                @(negedge clk);
                req_valid = 1'b0;
                return;
            end
        end
        check("req_accept", 0, 1);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        check("rsp_wait", 0, 1);
    endtask

    task automatic run_txn(input string tag, input logic w, input logic [5:0] a, input logic wd,
                           input logic [23:0] d, input int nb, input logic [31:0] exp_tx,
                           input logic [3:0] exp_cs, input logic [23:0] exp_rd);
        int base;
        int rc;
        logic [31:0] etx;
        etx  = exp_tx;
        base = log_n;
        rc   = rsp_cnt;
        send_req(w, a, wd, d);
        wait_rsp();
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, rsp_err, 0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rsp_once"}, rsp_cnt - rc, 1);
        check({tag, "_nbytes"}, log_n - base, nb);
        for (int i = 0; i < nb; i++) begin
            check($sformatf("%s_tx%0d", tag, i), tx_log[base+i], etx[31-8*i -: 8]);
            check($sformatf("%s_cs%0d", tag, i), cs_log[base+i], exp_cs[3-i]);
        end
    endtask

    initial begin
        int base;
        int rc;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wide  = 1'b0;
        req_wdata = '0;
        spi_rx    = '0;
        spi_busy  = 1'b0;
        spi_new_data = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_cs_end", spi_cs_end, 1);
        check("rst_start", spi_start, 0);
        check("rst_tx", spi_tx, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", req_ready, 1);

        // 8-bit read
        push_rx(8'h5A); push_rx(8'h3C);
        run_txn("rd8", 1'b0, 6'h02, 1'b0, 24'h0, 2, 32'h0200_0000, 4'b0100, 24'h00003C);

        // 24-bit write
        push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_rx(8'h44);
        run_txn("wr24", 1'b1, 6'h10, 1'b1, 24'hABCDEF, 4, 32'h50AB_CDEF, 4'b0001, 24'h0);

        // 24-bit read
        push_rx(8'hFF); push_rx(8'h12); push_rx(8'h34); push_rx(8'h56);
        run_txn("rd24", 1'b0, 6'h1B, 1'b1, 24'h0, 4, 32'h1B00_0000, 4'b0001, 24'h123456);

        // watchdog timeout
        eng_mute = 1'b1;
        base = log_n;
        send_req(1'b0, 6'h05, 1'b0, 24'h0);
        wait_rsp();
        check("to_err", rsp_err, 1);
        check("to_rdata", rsp_rdata, 0);
        check("to_latency", cyc - start_cyc, 64);
        check("to_cs_held", spi_cs_end, 0);
        check("to_nbytes", log_n - base, 1);
        @(negedge clk);
        check("to_ready", req_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        eng_mute = 1'b0;

        // spurious new_data in IDLE, then back-to-back with req_valid held
        push_rx(8'h00); push_rx(8'h66); push_rx(8'h01); push_rx(8'h02);
        base = log_n;
        rc   = rsp_cnt;
        @(negedge clk);
        spur_req++;
        repeat (3) @(negedge clk);
        check("spur_busy", busy, 0);
        check("spur_rsp", rsp_cnt - rc, 0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 6'h08;
        req_wide  = 1'b0;
        req_wdata = 24'h0;
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 6'h09;
        req_wdata = 24'h0000C3;
        wait_rsp();
        check("b2b_a_rdata", rsp_rdata, 24'h000066);
        check("b2b_a_ready", req_ready, 0);
        check("b2b_a_nbytes", log_n - base, 2);
        @(negedge clk);
        check("b2b_idle_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_b_busy", busy, 1);
        wait_rsp();
        check("b2b_b_rdata", rsp_rdata, 0);
        check("b2b_b_err", rsp_err, 0);
        @(negedge clk);
        check("b2b_rsp_cnt", rsp_cnt - rc, 2);
        check("b2b_b_tx0", tx_log[base+2], 8'h49);
        check("b2b_b_tx1", tx_log[base+3], 8'hC3);

        // reset in the middle of a byte
        eng_lat = 20;
        send_req(1'b0, 6'h07, 1'b0, 24'h0);
        for (int i = 0; i < 50 && !spi_busy; i++) @(negedge clk);
        check("mid_engine_busy", spi_busy, 1);
        repeat (3) @(negedge clk);
        rc = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cs_end", spi_cs_end, 1);
        check("mid_rst_rsp", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_no_rsp", rsp_cnt - rc, 0);
        eng_lat = 4;
        push_rx(8'h77); push_rx(8'hA5);
        run_txn("post_rst", 1'b0, 6'h03, 1'b0, 24'h0, 2, 32'h0300_0000, 4'b0100, 24'h0000A5);

        check("tx_cs_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdc_reg_sequencer.md
Name: tdc_reg_sequencer

Overview:
- Transaction-level front end for the TDC SPI byte engine (tdc_spi_master_5).
- Turns one register read/write request into a chip-select-framed burst: command byte, then 1 or 3 data bytes.
- Drives the byte engine's start/data/CS_END inputs and assembles the returned bytes into a response word.
- Sits between the measurement control FSM (upstream) and the byte engine (downstream).

Parameters:
TIMEOUT_CYCLES, 1024, max clk cycles to wait for spi_new_data per byte before aborting (>=64)
TO_W, 10, width of watchdog counter (>= clog2(TIMEOUT_CYCLES))

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request (high only in IDLE)
req_write  in  1  1=register write, 0=register read
req_addr  in  6  TDC register address
req_wide  in  1  0=8-bit register (1 data byte), 1=24-bit register (3 data bytes)
req_wdata  in  24  write data, right-aligned; [7:0] used when req_wide=0
rsp_valid  out  1  one-cycle pulse: transaction finished
rsp_rdata  out  24  read data, right-aligned, zero-extended; 0 for writes and errors
rsp_err  out  1  qualified by rsp_valid; 1 = watchdog timeout
busy  out  1  high whenever state != IDLE
spi_start  out  1  one-cycle start pulse to byte engine
spi_tx  out  8  byte to send (byte engine data_in)
spi_cs_end  out  1  1 = release CS after this byte (byte engine CS_END)
spi_rx  in  8  received byte (byte engine data_out)
spi_busy  in  1  byte engine busy
spi_new_data  in  1  byte engine byte-complete pulse

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE; spi_start=0, spi_tx=0, spi_cs_end=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, watchdog=0. Reset mid-burst abandons the transaction with no response. The byte engine shares rst.
- All outputs are registered. req_ready = (state==IDLE) & ~rst.
- Command byte: {1'b0 (no auto-increment), req_write, req_addr}.
- Byte count: 2 if req_wide=0, 4 if req_wide=1. Data bytes are sent MSB first: wdata[23:16], [15:8], [7:0]. For reads, data bytes are sent as 8'h00.
- States:
  - IDLE: on req_valid & req_ready, latch the request; set remaining = byte count; load spi_tx = command byte; spi_cs_end = (remaining==1), which is never true for the command byte. Go to ISSUE.
  - ISSUE: if spi_busy=0, assert spi_start for exactly one cycle, clear watchdog, go to WAIT. If spi_busy=1, hold in ISSUE.
  - WAIT: spi_tx and spi_cs_end held stable for the whole byte, because the engine samples them late. The watchdog increments each cycle.
    - On spi_new_data: if the byte was a data byte of a read, rdata <= {rdata[15:0], spi_rx}; the command-phase rx byte is discarded. Decrement remaining.
    - If remaining becomes 0, go to DONE. Otherwise load the next spi_tx, set spi_cs_end = (remaining_after==1), and go to ISSUE.
    - If the watchdog reaches TIMEOUT_CYCLES-1 with no spi_new_data, go to ERR.
  - DONE: rsp_valid=1 for one cycle, rsp_err=0, rsp_rdata = read ? rdata (8-bit zero-extended) : 0. Go to IDLE.
  - ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0 for one cycle; go to IDLE.
- Timeout does not release CS; upstream must reset after an error.
- spi_cs_end=0 for every byte except the last, so CS stays low across the burst.
- spi_new_data arriving in any state other than WAIT is ignored.
- req_valid while busy is not accepted; the requester holds it until req_ready.
- Back-to-back requests: accept in the cycle after DONE at earliest (IDLE lasts >=1 cycle).
- Latency (IDLE to rsp_valid) = sum of per-byte engine times + 2 cycles per byte + 2.

Decomposition:
- Shared package tdc_pkg: command-byte field positions (AUTO_INC bit 7, RW bit 6, ADDR [5:0]), state encodings, and byte-count constants (BYTES_NARROW=2, BYTES_WIDE=4).
- No sub-module; the watchdog counter is inline.

Test Plan:
- Read 8-bit addr 0x02, engine model returns 0x5A,0x3C -> spi_tx sequence 0x02,0x00; cs_end 0,1; rsp_valid once, rsp_rdata=0x00003C, rsp_err=0.
- Write 24-bit addr 0x10 wdata 0xABCDEF -> spi_tx 0x50,0xAB,0xCD,0xEF; cs_end 0,0,0,1; 4 spi_start pulses; rsp_rdata=0.
- Read 24-bit addr 0x1B, rx bytes 0xFF,0x12,0x34,0x56 -> rsp_rdata=0x123456; spi_tx/cs_end stable from each start until its new_data.
- Engine never pulses new_data, TIMEOUT_CYCLES=64 -> rsp_valid with rsp_err=1 exactly 64 cycles after the start pulse; req_ready returns next cycle.
- req_valid held high during a burst, plus a spurious new_data in IDLE -> second request accepted only after DONE; spurious pulse ignored.
- rst asserted mid-WAIT -> next cycle busy=0, spi_cs_end=1, no rsp_valid; a fresh read then completes normally.
